cla_5bit_sub: RTL and testbench

Inverse of the 5-bit carry-lookahead adder. Given a 6-bit adder result and one addend, the block recovers the other addend: o_add2 = i_sum - i_add1. It is a 2-stage pipelined carry-lookahead subtractor with valid/ready handshakes on both sides. It flags results that are not representable and keeps a saturating count of them. It sits downstream of adder blocks, in check and decode paths.

---
 rtl/cla_5bit_sub_if.sv | 26 ++
 rtl/cla_5bit_sub.sv | 105 ++++++++++
 tb/tb_cla_5bit_sub.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cla_5bit_sub_if.sv
// Operand/result handshake bundle for the carry-lookahead subtractor.
// The slave view belongs to the subtractor, the master view to whatever feeds and drains it.
interface cla_5bit_sub_if #(
   parameter int WIDTH     = 5,
   parameter int ERR_CNT_W = 8
);
   logic                 i_valid;
   logic                 o_ready;
   logic [WIDTH:0]       i_sum;
   logic [WIDTH-1:0]     i_add1;
   logic                 o_valid;
   logic                 i_ready;
   logic [WIDTH-1:0]     o_add2;
   logic                 o_err;
   logic [ERR_CNT_W-1:0] o_err_cnt;

   modport slave (
      input  i_valid, i_sum, i_add1, i_ready,
      output o_ready, o_valid, o_add2, o_err, o_err_cnt
   );

   modport master (
      output i_valid, i_sum, i_add1, i_ready,
      input  o_ready, o_valid, o_add2, o_err, o_err_cnt
   );
endinterface

// File: rtl/cla_5bit_sub.sv
// Two-stage carry-lookahead subtractor: recovers o_add2 = i_sum - i_add1, flags
// unrepresentable results and keeps a saturating count of delivered errors.
module cla_5bit_sub #(
   parameter int WIDTH     = 5,
   parameter int ERR_CNT_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   cla_5bit_sub_if.slave     bus
);

   logic [WIDTH:0]       w_a;
   logic [WIDTH:0]       w_b;
   logic                 w_adv1;
   logic                 w_adv2;
   logic [WIDTH+1:0]     w_c;
   logic [WIDTH:0]       w_diff;
   logic                 w_err;

   logic                 r_v1;
   logic [WIDTH:0]       r_g1;
   logic [WIDTH:0]       r_p1;
   logic [WIDTH:0]       r_x1;
   logic                 r_v2;
   logic [WIDTH-1:0]     r_add2;
   logic                 r_err;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   // Subtraction as a + ~b + 1; the +1 enters as carry-in of the lookahead.
   assign w_a = bus.i_sum;
   assign w_b = ~{1'b0, bus.i_add1};

   assign w_adv2      = !r_v2 || bus.i_ready;
   assign w_adv1      = !r_v1 || w_adv2;
   assign bus.o_ready = w_adv1;

   // Each carry is a flat sum of products over G/P (no carry feeds the next one):
   // c[i+1] = G[i] | P[i]G[i-1] | ... | P[i]..P[0]cin, with cin = 1.
   always_comb begin
      logic [WIDTH+1:0] c;
      logic             prod;
      // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
      c    = '0;
      prod = 1'b0;
      c[0] = 1'b1;
      for (int i = 0; i <= WIDTH; i++) begin
         c[i+1] = 1'b1;
         for (int j = 0; j <= i; j++) begin
            c[i+1] = c[i+1] & r_p1[j];
         end
         for (int j = 0; j <= i; j++) begin
            prod = r_g1[j];
            for (int k = j + 1; k <= i; k++) begin
               prod = prod & r_p1[k];
            end
            c[i+1] = c[i+1] | prod;
         end
      end
      w_c = c;
   end

   // No carry-out means a borrow; carry-out with diff[WIDTH] set means the result exceeds WIDTH bits.
   assign w_diff = r_x1 ^ w_c[WIDTH:0];
   assign w_err  = !w_c[WIDTH+1] || w_diff[WIDTH];

   // NOTE: stage-1 operand terms are only observed when r_v1 is set, so they carry no reset.
   always_ff @(posedge i_clk) begin
      if (w_adv1 && bus.i_valid) begin
         r_g1 <= w_a & w_b;
         r_p1 <= w_a | w_b;
         r_x1 <= w_a ^ w_b;
      end
   end

   // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_add2    <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         if (w_adv1) begin
            r_v1 <= bus.i_valid;
         end
         if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
               r_add2 <= w_err ? '0 : w_diff[WIDTH-1:0];
               r_err  <= w_err;
            end
         end
         if (r_v2 && bus.i_ready && r_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
         end
      end
   end

   assign bus.o_valid   = r_v2;
   assign bus.o_add2    = r_add2;
   assign bus.o_err     = r_err;
   assign bus.o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_cla_5bit_sub.sv
// Scoreboard bench for cla_5bit_sub: the driver queues expected results on each
// accepted pair, a negedge monitor pops and compares on each output handshake.
module tb_cla_5bit_sub;

   typedef struct packed {
      logic [4:0] add2;
      logic       err;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   cyc;
   int   out_cnt;
   int   exp_cnt;
   exp_t q[$];

   cla_5bit_sub_if #(.WIDTH(5), .ERR_CNT_W(8)) bus ();

   cla_5bit_sub #(.WIDTH(5), .ERR_CNT_W(8)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic exp_t model(input int s, input int a);
      exp_t e;
      int   d;
      d      = s - a;
      e.err  = (d < 0) || (d > 31);
      e.add2 = e.err ? 5'd0 : d[4:0];
      return e;
   endfunction

   // Monitor: every output handshake is compared against the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && bus.o_valid && bus.i_ready) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got add2=%0d err=%0d with nothing outstanding",
                     bus.o_add2, bus.o_err);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("add2", 32'(bus.o_add2), 32'(e.add2));
            check("err", 32'(bus.o_err), 32'(e.err));
            check("err_cnt_before", 32'(bus.o_err_cnt), 32'(exp_cnt));
            if (e.err && exp_cnt < 255) exp_cnt++;
            out_cnt++;
         end
      end
   end

   // Presents a pair and waits (bounded) for acceptance; returns #1 after the accepting edge.
   task automatic send(input int s, input int a);
      bit done;
      int n;
      done        = 1'b0;
      n           = 0;
      bus.i_valid = 1'b1;
      bus.i_sum   = 6'(s);
      bus.i_add1  = 5'(a);
      while (!done && n < 200) begin
         @(negedge clk);
         if (bus.o_ready) begin
            q.push_back(model(s, a));
            done = 1'b1;
         end
         n++;
      end
      @(posedge clk);
      #1;
      check("accept_timeout", 32'(done), 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_q_empty", 32'(q.size()), 32'd0);
   endtask

   initial begin
      int c0;
      int o0;
      n_checks    = 0;
      n_fail      = 0;
      cyc         = 0;
      out_cnt     = 0;
      exp_cnt     = 0;
      rst         = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_sum   = '0;
      bus.i_add1  = '0;
      bus.i_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_o_valid", 32'(bus.o_valid), 32'd0);
      check("rst_o_add2", 32'(bus.o_add2), 32'd0);
      check("rst_o_err", 32'(bus.o_err), 32'd0);
      check("rst_o_err_cnt", 32'(bus.o_err_cnt), 32'd0);
      check("rst_o_ready", 32'(bus.o_ready), 32'd1);

      // Basic pair and two-cycle latency.
      send(13, 6);
      bus.i_valid = 1'b0;
      check("lat_cycle1_o_valid", 32'(bus.o_valid), 32'd0);
      @(posedge clk);
      #1;
      check("lat_cycle2_o_valid", 32'(bus.o_valid), 32'd1);
      check("basic_o_add2", 32'(bus.o_add2), 32'd7);
      check("basic_o_err", 32'(bus.o_err), 32'd0);
      check("basic_o_err_cnt", 32'(bus.o_err_cnt), 32'd0);
      drain();

      // Extremes, borrow, overflow.
      send(62, 31);
      send(0, 0);
      bus.i_valid = 1'b0;
      drain();
      send(3, 5);
      bus.i_valid = 1'b0;
      drain();
      check("borrow_err_cnt", 32'(bus.o_err_cnt), 32'd1);
      send(40, 2);
      send(33, 2);
      bus.i_valid = 1'b0;
      drain();
      check("overflow_err_cnt", 32'(bus.o_err_cnt), 32'd2);

      // Backpressure: fill both stages, hold, then release.
      o0          = out_cnt;
      bus.i_ready = 1'b0;
      send(10, 3);
      send(20, 4);
      bus.i_valid = 1'b1;
      bus.i_sum   = 6'd30;
      bus.i_add1  = 5'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_o_ready", 32'(bus.o_ready), 32'd0);
         check("bp_o_valid", 32'(bus.o_valid), 32'd1);
         check("bp_hold_o_add2", 32'(bus.o_add2), 32'd7);
      end
      @(posedge clk);
      #1;
      bus.i_ready = 1'b1;
      send(30, 5);
      bus.i_valid = 1'b0;
      drain();
      check("bp_out_count", 32'(out_cnt - o0), 32'd3);

      // Exhaustive back-to-back sweep at full throughput.
      o0 = out_cnt;
      c0 = cyc;
      for (int s = 0; s < 64; s++) begin
         for (int a = 0; a < 32; a++) begin
            send(s, a);
         end
      end
      check("sweep_cycles", 32'(cyc - c0), 32'd2048);
      bus.i_valid = 1'b0;
      drain();
      check("sweep_out_count", 32'(out_cnt - o0), 32'd2048);

      // Error counter saturation.
      for (int i = 0; i < 300; i++) begin
         send(3, 5);
      end
      bus.i_valid = 1'b0;
      drain();
      check("sat_err_cnt", 32'(bus.o_err_cnt), 32'd255);

      // Reset with both stages full.
      bus.i_ready = 1'b0;
      send(10, 3);
      send(20, 4);
      bus.i_valid = 1'b0;
      check("full_o_ready", 32'(bus.o_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      exp_cnt = 0;
      check("mid_rst_o_valid", 32'(bus.o_valid), 32'd0);
      check("mid_rst_o_err_cnt", 32'(bus.o_err_cnt), 32'd0);
      check("mid_rst_o_ready", 32'(bus.o_ready), 32'd1);
      bus.i_ready = 1'b1;
      send(13, 6);
      bus.i_valid = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no completion expected completion before time limit");
      $fatal(1, "time limit");
   end

endmodule
